// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined ALU: operation encodings and
// bit positions inside the 4-bit {N,Z,C,V} flags word.
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOTA  = 4'd5,
        OP_SHL   = 4'd6,
        OP_SHR   = 4'd7,
        OP_SRA   = 4'd8,
        OP_SLT   = 4'd9,
        OP_PASSB = 4'd10
    } alu_op_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_pipe_alu_core.sv
// Purely combinational ALU: (a, b, op) -> (y, NZCV flags, bad_op).
// Undefined op codes force y and flags to zero and raise bad_op.
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    output logic [WIDTH-1:0] y_o,
    output logic [3:0]       flags_o,
    output logic             bad_op_o
);

    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH:0] WIDTH_L = (WIDTH + 1)'(WIDTH);

    logic [WIDTH:0]   sum, diff, shl_ext, shr_ext, sra_ext;
    logic             sh_big;
    logic [WIDTH-1:0] y;
    logic             c, v, bad;

    assign sum    = {1'b0, a_i} + {1'b0, b_i};
    assign diff   = {1'b0, a_i} - {1'b0, b_i};
    assign sh_big = ({1'b0, b_i} >= WIDTH_L);

    // One guard bit on the exit side of each shift catches the last bit shifted out.
    assign shl_ext = {1'b0, a_i} << b_i;
    assign shr_ext = {a_i, 1'b0} >> b_i;
    assign sra_ext = $signed({a_i, 1'b0}) >>> b_i;

    always_comb begin
        y   = '0;
        c   = 1'b0;
        v   = 1'b0;
        bad = 1'b0;
        case (alu_op_t'(op_i))
            OP_ADD: begin
                y = sum[MSB:0];
                c = sum[WIDTH];
                v = (a_i[MSB] == b_i[MSB]) && (y[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                y = diff[MSB:0];
                c = ~diff[WIDTH];
                v = (a_i[MSB] != b_i[MSB]) && (y[MSB] != a_i[MSB]);
            end
            OP_AND:  y = a_i & b_i;
            OP_OR:   y = a_i | b_i;
            OP_XOR:  y = a_i ^ b_i;
            OP_NOTA: y = ~a_i;
            OP_SHL: begin
                if (!sh_big) begin
                    y = shl_ext[MSB:0];
                    c = shl_ext[WIDTH];
                end
            end
            OP_SHR: begin
                if (!sh_big) begin
                    y = shr_ext[WIDTH:1];
                    c = shr_ext[0];
                end
            end
            OP_SRA: begin
                if (sh_big) begin
                    y = {WIDTH{a_i[MSB]}};
                end else begin
                    y = sra_ext[WIDTH:1];
                    c = sra_ext[0];
                end
            end
            OP_SLT:   y = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_PASSB: y = b_i;
            default:  bad = 1'b1;
        endcase
    end

    always_comb begin
        flags_o = '0;
        if (!bad) begin
            flags_o[FLAG_N] = y[MSB];
            flags_o[FLAG_Z] = (y == '0);
            flags_o[FLAG_C] = c;
            flags_o[FLAG_V] = v;
        end
    end

    assign y_o      = y;
    assign bad_op_o = bad;

endmodule

// File: rtl/alu_pipe.sv
// Configurable-depth ALU pipeline with valid/ready on both sides, full
// backpressure, tag passthrough and a count of delivered results.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int TAG_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags,
    output logic             bad_op,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] ops_done
);

    // Handshake: a beat moves on a side only in a cycle where valid && ready
    // are both high at the rising edge; valid never depends on ready, and
    // in_ready is a combinational function of slot occupancy and out_ready.

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] ld;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [3:0]        op_q;
    logic [TAG_W-1:0]  tag_q   [STAGES];
    logic [WIDTH-1:0]  y_q     [1:STAGES-1];
    logic [3:0]        flags_q [1:STAGES-1];
    logic              bad_q   [1:STAGES-1];
    logic [WIDTH-1:0]  core_y;
    logic [3:0]        core_flags;
    logic              core_bad;
    logic [CNT_W-1:0]  ops_done_q, ops_done_d;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .y_o      (core_y),
        .flags_o  (core_flags),
        .bad_op_o (core_bad)
    );

    // Slot i advances when any slot at or after it is empty (bubble collapse) or the sink takes a beat.
    always_comb begin
        ld = '0;
        for (int i = 0; i < STAGES; i++) begin
            ld[i] = out_ready;
            for (int j = i; j < STAGES; j++) begin
                if (!vld_q[j]) ld[i] = 1'b1;
            end
        end
    end

    assign ops_done_d = (vld_q[STAGES-1] && out_ready) ? ops_done_q + CNT_W'(1) : ops_done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            ops_done_q <= '0;
            for (int i = 0; i < STAGES; i++) tag_q[i] <= '0;
            for (int i = 1; i < STAGES; i++) begin
                y_q[i]     <= '0;
                flags_q[i] <= '0;
                bad_q[i]   <= 1'b0;
            end
        end else begin
            ops_done_q <= ops_done_d;
            if (ld[0]) begin
                vld_q[0] <= in_valid;
                if (in_valid) begin
                    a_q      <= a;
                    b_q      <= b;
                    op_q     <= op;
                    tag_q[0] <= in_tag;
                end
            end
            if (ld[1]) begin
                vld_q[1] <= vld_q[0];
                if (vld_q[0]) begin
                    y_q[1]     <= core_y;
                    flags_q[1] <= core_flags;
                    bad_q[1]   <= core_bad;
                    tag_q[1]   <= tag_q[0];
                end
            end
            for (int i = 2; i < STAGES; i++) begin
                if (ld[i]) begin
                    vld_q[i] <= vld_q[i-1];
                    if (vld_q[i-1]) begin
                        y_q[i]     <= y_q[i-1];
                        flags_q[i] <= flags_q[i-1];
                        bad_q[i]   <= bad_q[i-1];
                        tag_q[i]   <= tag_q[i-1];
                    end
                end
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = vld_q[STAGES-1];
    assign y         = y_q[STAGES-1];
    assign flags     = flags_q[STAGES-1];
    assign bad_op    = bad_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign ops_done  = ops_done_q;

endmodule
